stage_mem_lsu: RTL and testbench

STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

---
 rtl/stage_mem_lsu.sv | 149 ++++++++++++++
 tb/tb_stage_mem_lsu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stage_mem_lsu.sv
// MEM stage load/store unit: two-state bus FSM, lane steering, load extension, writeback.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign_err and skip the bus.
module stage_mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic        reg_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]  state;
    logic [1:0]  l_size, l_off;
    logic        l_unsigned, l_rw, l_load;
    logic [4:0]  l_rd;
    logic        skid_v;
    logic [4:0]  skid_rd;
    logic [31:0] skid_data;

    logic        accept, is_mem, misal, go_bus, done, ld_wb, alu_wb;
    logic [3:0]  be;
    logic [31:0] wdata, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign stall  = (state == BUS) & ~bus_ready;
    assign accept = in_valid & ~stall;
    assign is_mem = mem_read | mem_write;
`ifdef MISALIGN_TRAP_EN
    assign misal  = ((mem_size == 2'b01) & alu_result[0]) | (mem_size[1] & (|alu_result[1:0]));
`else
    assign misal  = 1'b0;
`endif
    assign go_bus = accept & is_mem & ~misal;
    assign done   = (state == BUS) & bus_ready;
    assign ld_wb  = done & l_load & l_rw;
    assign alu_wb = accept & ~is_mem & reg_write;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (mem_size)
            2'b00: begin
                be    = 4'b0001 << alu_result[1:0];
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = bus_rdata[{l_off, 3'b000} +: 8];
    assign ld_half = bus_rdata[{l_off[1], 4'b0000} +: 16];

    always_comb begin
        case (l_size)
            2'b00:   ld_val = {{24{~l_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~l_unsigned & ld_half[15]}}, ld_half};
            default: ld_val = bus_rdata;
        endcase
    end

    // A load completing in the same cycle a reg-writing ALU op is accepted would need two
    // writebacks at once; the load goes first and the ALU result slips one cycle via the skid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_be       <= 4'b0;
            bus_addr     <= 32'b0;
            bus_wdata    <= 32'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'b0;
            wb_data      <= 32'b0;
            misalign_err <= 1'b0;
            l_size       <= 2'b0;
            l_off        <= 2'b0;
            l_unsigned   <= 1'b0;
            l_rw         <= 1'b0;
            l_load       <= 1'b0;
            l_rd         <= 5'b0;
            skid_v       <= 1'b0;
            skid_rd      <= 5'b0;
            skid_data    <= 32'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= accept & is_mem & misal;
            if (done) begin
                state   <= IDLE;
                bus_req <= 1'b0;
            end
            if (go_bus) begin
                state      <= BUS;
                bus_req    <= 1'b1;
                bus_we     <= mem_write;
                bus_be     <= be;
                bus_addr   <= {alu_result[31:2], 2'b00};
                bus_wdata  <= wdata;
                l_size     <= mem_size;
                l_off      <= alu_result[1:0];
                l_unsigned <= mem_unsigned;
                l_rw       <= reg_write;
                l_load     <= ~mem_write;
                l_rd       <= rd;
            end
            if (ld_wb) begin
                wb_valid <= 1'b1;
                wb_rd    <= l_rd;
                wb_data  <= ld_val;
            end else if (skid_v) begin
                wb_valid <= 1'b1;
                wb_rd    <= skid_rd;
                wb_data  <= skid_data;
            end else if (alu_wb) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd;
                wb_data  <= alu_result;
            end
            skid_v <= (ld_wb | skid_v) & alu_wb;
            if ((ld_wb | skid_v) & alu_wb) begin
                skid_rd   <= rd;
                skid_data <= alu_result;
            end
        end
    end
endmodule

// File: tb/tb_stage_mem_lsu.sv
// Bench for stage_mem_lsu: directed scenarios then random traffic against an in-order
// transaction model (expected bus request + queue of pending writebacks, one retired per cycle).
module tb_stage_mem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0]  mem_size = 2'b0;
    logic        mem_unsigned = 1'b0, reg_write = 1'b0, bus_ready = 1'b0;
    logic [31:0] alu_result = 32'b0, store_data = 32'b0, bus_rdata = 32'b0;
    logic [4:0]  rd = 5'b0;
    logic        stall, bus_req, bus_we, wb_valid, misalign_err;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, wb_data;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    stage_mem_lsu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write(reg_write),
        .alu_result(alu_result), .store_data(store_data), .rd(rd), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign_err(misalign_err)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // model: outstanding request and ordered writebacks still owed
    bit          pend = 0, p_load, p_rw, p_uns, p_we, e_mis = 0;
    logic [1:0]  p_size, p_off;
    logic [4:0]  p_rd;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_wdata;
    logic [36:0] wbq[$];

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] off, input bit uns);
        int sh;
        logic [31:0] v;
        if (sz == 2'd0) begin
            sh = int'(off) * 8;
            v = (w >> sh) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            sh = (int'(off) / 2) * 16;
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else v = w;
        return v;
    endfunction

    // One clock: drive at negedge, check stall, advance model, check registered outputs.
    task automatic step(input bit iv, input bit rdm, input bit wrm, input logic [1:0] sz,
                        input bit uns, input bit rw, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rdx, input bit rdy, input logic [31:0] rdat, input bit rs);
        bit e_stall, mis;
        logic [36:0] w;
        in_valid = iv; mem_read = rdm; mem_write = wrm; mem_size = sz; mem_unsigned = uns;
        reg_write = rw; alu_result = a; store_data = sd; rd = rdx; bus_ready = rdy;
        bus_rdata = rdat; rst = rs;
        #1;
        e_stall = pend & ~rdy;
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        e_mis = 0;
        if (rs) begin
            pend = 0;
            wbq.delete();
        end else begin
            if (pend && rdy) begin
                pend = 0;
                if (p_load && p_rw) wbq.push_back({p_rd, load_val(rdat, p_size, p_off, p_uns)});
            end
            if (iv && !e_stall) begin
                if (rdm || wrm) begin
`ifdef MISALIGN_TRAP_EN
                    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
                    mis = 0;
`endif
                    if (mis) e_mis = 1;
                    else begin
                        pend = 1; p_load = !wrm; p_we = wrm; p_rw = rw; p_uns = uns;
                        p_size = sz; p_off = a[1:0]; p_rd = rdx; p_addr = a & 32'hFFFF_FFFC;
                        if (sz == 2'd0) begin
                            p_be = 4'(1 << a[1:0]); p_wdata = sd[7:0] * 32'h0101_0101;
                        end else if (sz == 2'd1) begin
                            p_be = 4'(3 << (a[1:0] & 2'd2)); p_wdata = sd[15:0] * 32'h0001_0001;
                        end else begin
                            p_be = 4'hF; p_wdata = sd;
                        end
                    end
                end else if (rw) wbq.push_back({rdx, a});
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (rs) begin
            chk("rst_we", {31'b0, bus_we}, 32'd0);
            chk("rst_be", {28'b0, bus_be}, 32'd0);
            chk("rst_addr", bus_addr, 32'd0);
            chk("rst_wdata", bus_wdata, 32'd0);
            chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
            chk("rst_wb_data", wb_data, 32'd0);
        end
        chk("bus_req", {31'b0, bus_req}, {31'b0, pend});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_mis});
        if (pend) begin
            chk("bus_addr", bus_addr, p_addr);
            chk("bus_be", {28'b0, bus_be}, {28'b0, p_be});
            chk("bus_we", {31'b0, bus_we}, {31'b0, p_we});
            if (p_we) chk("bus_wdata", bus_wdata, p_wdata);
        end
        if (wbq.size() > 0) begin
            w = wbq.pop_front();
            chk("wb_valid", {31'b0, wb_valid}, 32'd1);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, w[36:32]});
            chk("wb_data", wb_data, w[31:0]);
        end else chk("wb_valid", {31'b0, wb_valid}, 32'd0);
    endtask

    task automatic idle(input bit rdy, input logic [31:0] rdat);
        step(0, 0, 0, 2'd0, 0, 0, 32'd0, 32'd0, 5'd0, rdy, rdat, 0);
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 2'd0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1);
        chk("reset_wb_valid", {31'b0, wb_valid}, 32'd0);

        // ALU op writes back after one cycle
        step(1, 0, 0, 2'd2, 0, 1, 32'h1234, 32'd0, 5'd5, 0, 32'd0, 0);
        chk("add_wb_data", wb_data, 32'h1234);
        chk("add_wb_rd", {27'b0, wb_rd}, 32'd5);

        // LB / LBU at 0x103 with three wait cycles
        for (int u = 0; u < 2; u++) begin
            step(1, 1, 0, 2'd0, bit'(u), 1, 32'h103, 32'd0, 5'd7, 0, 32'd0, 0);
            chk("lb_addr", bus_addr, 32'h100);
            chk("lb_be", {28'b0, bus_be}, 32'h8);
            for (int k = 0; k < 3; k++) idle(0, 32'd0);
            idle(1, 32'h80FF_FFFF);
            chk("lb_data", wb_data, u ? 32'h0000_0080 : 32'hFFFF_FF80);
        end

        // SH at 0x202
        step(1, 0, 1, 2'd1, 0, 0, 32'h202, 32'hABCD, 5'd3, 0, 32'd0, 0);
        chk("sh_be", {28'b0, bus_be}, 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        idle(1, 32'd0);

        // back-to-back LW, second issued in the first one's ready cycle
        step(1, 1, 0, 2'd2, 0, 1, 32'h10, 32'd0, 5'd1, 0, 32'd0, 0);
        step(1, 1, 0, 2'd2, 0, 1, 32'h20, 32'd0, 5'd2, 1, 32'h1111_1111, 0);
        chk("b2b_addr", bus_addr, 32'h20);
        chk("b2b_req", {31'b0, bus_req}, 32'd1);
        idle(1, 32'h2222_2222);
        idle(0, 32'd0);

        // reset mid-transaction, then a late ready
        step(1, 1, 0, 2'd2, 0, 1, 32'h30, 32'd0, 5'd4, 0, 32'd0, 0);
        step(0, 0, 0, 2'd0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 32'd0, 1);
        idle(1, 32'h5555_5555);
        chk("abort_no_wb", {31'b0, wb_valid}, 32'd0);

        // LW at 0x101
        step(1, 1, 0, 2'd2, 0, 1, 32'h101, 32'd0, 5'd6, 0, 32'd0, 0);
`ifdef MISALIGN_TRAP_EN
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_req", {31'b0, bus_req}, 32'd0);
        idle(0, 32'd0);
`else
        chk("lw101_addr", bus_addr, 32'h100);
        chk("lw101_be", {28'b0, bus_be}, 32'hF);
        idle(1, 32'hCAFE_F00D);
`endif
        idle(0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int op;
            bit rdy;
            op  = $urandom_range(0, 2);
            rdy = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 3) != 0, op == 1, op == 2, 2'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom, $urandom,
                 5'($urandom_range(0, 31)), rdy, $urandom, $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
